// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage: fetch PC register, valid/ready
// fetch handshake, trap/redirect priority, misalign fault parking and fetch counting.
// Optional compressed-instruction support is enabled by defining PC_GEN_RVC_EN.
module pc_gen #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                redirect_valid_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    input  logic                trap_valid_i,
    input  logic                is_compressed_i,
    input  logic                if_ready_i,
    output logic [XLEN-1:0]     pc_o,
    output logic                pc_valid_o,
    output logic [XLEN-1:0]     pc_plus_o,
    output logic                misalign_o,
    output logic [31:0]         fetch_count_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } state_t;

    localparam logic [XLEN-1:0] STEP_WORD = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] STEP_HALF = {{(XLEN-3){1'b0}}, 3'b010};

    state_t             state_r;
    logic [XLEN-1:0]    pc_r;
    logic               pc_valid_r;
    logic               misalign_r;
    logic [31:0]        fetch_count_r;

    logic [XLEN-1:0]    step_s;
    logic [XLEN-1:0]    pc_plus_s;
    logic               accept_s;
    logic               misaligned_s;
    logic               redirect_take_s;

`ifdef PC_GEN_RVC_EN
    // Step size and target alignment for a mixed 16/32-bit instruction stream.
    always_comb begin
        step_s       = STEP_WORD;
        misaligned_s = 1'b0;
        if (is_compressed_i) begin
            step_s = STEP_HALF;
        end else begin
            step_s = STEP_WORD;
        end
        if (redirect_pc_i[0] != 1'b0) begin
            misaligned_s = 1'b1;
        end else begin
            misaligned_s = 1'b0;
        end
    end
`else
    logic unused_compressed_s;
    assign unused_compressed_s = is_compressed_i;

    // Step size and target alignment for a 32-bit-only instruction stream.
    always_comb begin
        step_s       = STEP_WORD;
        misaligned_s = 1'b0;
        if (redirect_pc_i[1:0] != 2'b00) begin
            misaligned_s = 1'b1;
        end else begin
            misaligned_s = 1'b0;
        end
        if (STEP_HALF == STEP_WORD) begin
            step_s = STEP_HALF;
        end else begin
            step_s = STEP_WORD;
        end
    end
`endif

    // Sequential link value and the fetch-accept / redirect qualifiers.
    always_comb begin
        pc_plus_s       = pc_r + step_s;
        accept_s        = pc_valid_r & if_ready_i & ~stall_i;
        redirect_take_s = 1'b0;
        if (redirect_valid_i && (state_r != FAULT)) begin
            redirect_take_s = 1'b1;
        end else begin
            redirect_take_s = 1'b0;
        end
    end

    // Fetch-PC state machine with trap > redirect > accept > hold priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= BOOT;
            pc_r          <= RESET_VECTOR;
            pc_valid_r    <= 1'b0;
            misalign_r    <= 1'b0;
            fetch_count_r <= 32'h0000_0000;
        end else begin
            // The counter sees accepts even when a trap or redirect wins the PC.
            if (accept_s) begin
                fetch_count_r <= fetch_count_r + 32'h0000_0001;
            end else begin
                fetch_count_r <= fetch_count_r;
            end

            if (trap_valid_i) begin
                state_r    <= RUN;
                pc_r       <= TRAP_VECTOR;
                pc_valid_r <= 1'b1;
                misalign_r <= 1'b0;
            end else if (redirect_take_s) begin
                pc_r <= redirect_pc_i;
                if (misaligned_s) begin
                    state_r    <= FAULT;
                    pc_valid_r <= 1'b0;
                    misalign_r <= 1'b1;
                end else begin
                    state_r    <= RUN;
                    pc_valid_r <= 1'b1;
                    misalign_r <= 1'b0;
                end
            end else begin
                case (state_r)
                    BOOT: begin
                        state_r    <= RUN;
                        pc_r       <= pc_r;
                        pc_valid_r <= 1'b1;
                        misalign_r <= 1'b0;
                    end
                    RUN: begin
                        state_r    <= RUN;
                        pc_valid_r <= 1'b1;
                        misalign_r <= 1'b0;
                        if (accept_s) begin
                            pc_r <= pc_plus_s;
                        end else begin
                            pc_r <= pc_r;
                        end
                    end
                    FAULT: begin
                        // Offending target stays visible for debug until a trap.
                        state_r    <= FAULT;
                        pc_r       <= pc_r;
                        pc_valid_r <= 1'b0;
                        misalign_r <= 1'b1;
                    end
                    default: begin
                        state_r    <= BOOT;
                        pc_r       <= RESET_VECTOR;
                        pc_valid_r <= 1'b0;
                        misalign_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pc_o          = pc_r;
    assign pc_valid_o    = pc_valid_r;
    assign pc_plus_o     = pc_plus_s;
    assign misalign_o    = misalign_r;
    assign fetch_count_o = fetch_count_r;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: expectations are queued when a step
// is driven and popped/compared one cycle later. Honours PC_GEN_RVC_EN.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        trap_valid_i;
    logic        is_compressed_i;
    logic        if_ready_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic [31:0] pc_plus_o;
    logic        misalign_o;
    logic [31:0] fetch_count_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] plus;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

`ifdef PC_GEN_RVC_EN
    localparam logic [31:0] FAULT_PC = 32'h0000_0203;
`else
    localparam logic [31:0] FAULT_PC = 32'h0000_0202;
`endif

    pc_gen #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_i(stall_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i(redirect_pc_i),
        .trap_valid_i(trap_valid_i),
        .is_compressed_i(is_compressed_i),
        .if_ready_i(if_ready_i),
        .pc_o(pc_o),
        .pc_valid_o(pc_valid_o),
        .pc_plus_o(pc_plus_o),
        .misalign_o(misalign_o),
        .fetch_count_o(fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] step_of(input logic ic);
`ifdef PC_GEN_RVC_EN
        return ic ? 32'd2 : 32'd4;
`else
        return 32'd4;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc"},    pc_o,                  32'h0000_0000);
        chk({tag, ".valid"}, {31'd0, pc_valid_o},   32'd0);
        chk({tag, ".mis"},   {31'd0, misalign_o},   32'd0);
        chk({tag, ".cnt"},   fetch_count_o,         32'h0000_0000);
        chk({tag, ".plus"},  pc_plus_o,             32'h0000_0004);
    endtask

    // Called at a negedge: drive inputs, queue expectation, compare after the edge.
    task automatic step(input string tag, input logic st, input logic rv, input logic [31:0] rpc,
                        input logic tv, input logic ic, input logic rdy,
                        input logic [31:0] epc, input logic ev, input logic em, input logic [31:0] ecnt);
        exp_t e;
        stall_i          = st;
        redirect_valid_i = rv;
        redirect_pc_i    = rpc;
        trap_valid_i     = tv;
        is_compressed_i  = ic;
        if_ready_i       = rdy;
        e.tag   = tag;
        e.pc    = epc;
        e.plus  = epc + step_of(ic);
        e.valid = ev;
        e.mis   = em;
        e.cnt   = ecnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".pc"},    pc_o,                e.pc);
        chk({e.tag, ".valid"}, {31'd0, pc_valid_o}, {31'd0, e.valid});
        chk({e.tag, ".mis"},   {31'd0, misalign_o}, {31'd0, e.mis});
        chk({e.tag, ".cnt"},   fetch_count_o,       e.cnt);
        chk({e.tag, ".plus"},  pc_plus_o,           e.plus);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
        trap_valid_i = 1'b0; is_compressed_i = 1'b0; if_ready_i = 1'b1;
        @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        //     tag          st    rv    rpc           tv    ic    rdy   pc            v     m     cnt
        step("boot",       1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'd0);
        step("run1",       1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'd1);
        step("run2",       1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'd2);
        step("run3",       1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b0, 32'd3);
        step("run4",       1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'd4);
        step("stall1",     1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'd4);
        step("stall2",     1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'd4);
        step("notready",   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 32'd4);
        step("resume",     1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0014, 1'b1, 1'b0, 32'd5);
        step("redir_stall",1'b1, 1'b1, 32'h200,      1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'd5);
        step("trap_wins",  1'b1, 1'b1, 32'h200,      1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'd5);
        step("redir_acc",  1'b0, 1'b1, 32'h300,      1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'd6);
`ifdef PC_GEN_RVC_EN
        step("half_ok",    1'b0, 1'b1, 32'h202,      1'b0, 1'b0, 1'b0, 32'h0000_0202, 1'b1, 1'b0, 32'd6);
        step("odd_fault",  1'b0, 1'b1, 32'h203,      1'b0, 1'b0, 1'b0, 32'h0000_0203, 1'b0, 1'b1, 32'd6);
`else
        step("mis_fault",  1'b0, 1'b1, 32'h202,      1'b0, 1'b0, 1'b0, 32'h0000_0202, 1'b0, 1'b1, 32'd6);
`endif
        step("fault_redir",1'b0, 1'b1, 32'h400,      1'b0, 1'b0, 1'b1, FAULT_PC,      1'b0, 1'b1, 32'd6);
        step("fault_hold", 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, FAULT_PC,      1'b0, 1'b1, 32'd6);
        step("fault_trap", 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'd6);
        step("post_trap",  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'd7);
        step("to_top",     1'b0, 1'b1, 32'hFFFF_FFFC,1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd7);
        step("pc_wrap",    1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'd8);
`ifdef PC_GEN_RVC_EN
        step("to_40",      1'b0, 1'b1, 32'h40,       1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b1, 1'b0, 32'd8);
        step("rvc_c",      1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_0042, 1'b1, 1'b0, 32'd9);
        step("rvc_w",      1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0046, 1'b1, 1'b0, 32'd10);
        step("rvc_c2",     1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_0048, 1'b1, 1'b0, 32'd11);
`endif

        // Preload the counter just below wrap, then accept once.
        force dut.fetch_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count_r;
        step("cnt_wrap",   1'b0, 1'b1, 32'h500,      1'b0, 1'b0, 1'b1, 32'h0000_0500, 1'b1, 1'b0, 32'd0);
        step("cnt_next",   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0504, 1'b1, 1'b0, 32'd1);

        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        @(posedge clk);
        #1;
        chk_reset("rst_held");
        @(negedge clk);
        rst = 1'b0;
        step("reboot",     1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'd0);
        step("reboot_run", 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the IF stage of the RISC-V pipeline, replacing the fixed PC+4 adder. It holds the architectural fetch PC in a register and presents it to instruction memory with a valid/ready handshake. It advances by the instruction step and honours stall, branch/jump redirect and trap redirect with fixed priority. It detects misaligned redirect targets and parks in a fault state until a trap is taken, and it counts accepted fetches.

## Interface
- XLEN, 32: PC and address width.
- RESET_VECTOR, 32'h0000_0000: PC value loaded by reset. XLEN bits wide, low 2 bits zero.
- TRAP_VECTOR, 32'h0000_0100: PC value loaded on trap. XLEN bits wide, low 2 bits zero.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hazard stall from ID; holds the PC.
- redirect_valid_i  in  1  taken branch/jump from EX.
- redirect_pc_i  in  XLEN  branch/jump target.
- trap_valid_i  in  1  exception/trap request.
- is_compressed_i  in  1  current instruction is 16-bit. Ignored unless PC_GEN_RVC_EN is defined.
- if_ready_i  in  1  instruction memory accepts pc_o this cycle.
- pc_o  out  XLEN  registered fetch PC.
- pc_valid_o  out  1  pc_o is a valid fetch request.
- pc_plus_o  out  XLEN  combinational pc_o + step, used as the link value.
- misalign_o  out  1  registered; high while in FAULT.
- fetch_count_o  out  32  accepted-fetch counter.

## Operation
- States: BOOT, RUN, FAULT (2-bit encoding).
- BOOT → RUN after one cycle. pc_valid_o=0 throughout BOOT.
- RUN: pc_valid_o=1.
- FAULT: pc_valid_o=0 and misalign_o=1.
- step = 4. With PC_GEN_RVC_EN defined: step = is_compressed_i ? 2 : 4.
- pc_plus_o = pc_o + step, truncated to XLEN; wraps modulo 2^XLEN (all-ones − 3 + 4 = 0).
- accept = pc_valid_o & if_ready_i & ~stall_i.
- Next-PC priority, evaluated each cycle in any state:
  1. trap_valid_i: pc ← TRAP_VECTOR, state ← RUN, misalign cleared.
  2. redirect_valid_i (BOOT or RUN only): pc ← redirect_pc_i. If the target is misaligned, state ← FAULT; otherwise state ← RUN.
  3. accept: pc ← pc_plus_o.
  4. Otherwise: pc holds.
- Misaligned target:
  - Without PC_GEN_RVC_EN: redirect_pc_i[1:0] != 0.
  - With PC_GEN_RVC_EN: redirect_pc_i[0] != 0.
- Redirect overrides stall_i and a deasserted if_ready_i; the in-flight PC is dropped and not counted.
- FAULT ignores redirect_valid_i, stall_i and if_ready_i. pc_o holds the offending target for debug until a trap.
- fetch_count_o increments by 1 on every accept and wraps 0xFFFF_FFFF → 0.
  - An accept in the same cycle as a trap or redirect still counts.

## Timing
- Reset (asynchronous assert): pc_o=RESET_VECTOR, pc_valid_o=0, misalign_o=0, fetch_count_o=0, state=BOOT.
- Reset release is synchronous to the next clk edge. First rising edge after release: state=RUN, pc_valid_o=1, pc_o=RESET_VECTOR.
- Latency from any redirect, trap or accept to the new pc_o: 1 cycle (registered).
- pc_plus_o has zero latency; it follows pc_o and is_compressed_i combinationally.
- misalign_o asserts 1 cycle after the faulting redirect and deasserts 1 cycle after trap_valid_i.
- Reset asserted mid-operation returns every output to its reset value immediately, independent of clk.

## Configuration
- PC_GEN_RVC_EN defined:
  - step is selected by is_compressed_i (2 or 4).
  - Halfword-aligned targets are legal; only bit 0 faults.
- PC_GEN_RVC_EN undefined:
  - step is fixed at 4 and is_compressed_i is unused.
  - Any target with a nonzero bit[1:0] faults.

## Test plan
- Reset, release, if_ready_i=1 for 4 cycles → pc_o = 0x0, 0x0 (BOOT), 0x4, 0x8, 0xC; pc_valid_o 0 then 1; fetch_count_o=3.
- In RUN at pc 0x10: stall_i=1 for 2 cycles, then if_ready_i=0 for 1 cycle → pc_o holds 0x10 and fetch_count_o does not change; release both → 0x14.
- stall_i=1 together with redirect_valid_i=1, redirect_pc_i=0x200 → pc_o=0x200 next cycle; same cycle with trap_valid_i=1 also asserted → pc_o=0x100.
- Redirect to 0x202 (macro off) → FAULT, misalign_o=1, pc_valid_o=0, pc_o=0x202; further redirects ignored; trap → pc_o=0x100, misalign_o=0. With the macro on, 0x202 is legal and 0x203 faults.
- Macro on, pc=0x40: is_compressed_i=1, 0, 1 with if_ready_i=1 → pc_o = 0x42, 0x46, 0x48; pc_plus_o tracks each step.
- pc=0xFFFF_FFFC with accept → pc_o=0x0. Preset fetch_count_o=0xFFFF_FFFF and accept once → 0x0. Assert rst mid-run → outputs at reset values before the next clk edge.
